// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Packs decoded instruction fields into 16-bit instruction words, buffers them
// in a small FIFO and writes them sequentially into instruction memory through
// a backpressured write port. Used to download a program before the pipeline
// is released.
//
// Word layout: {opcode[15:12], rs1[11:10], rs2[9:8], rd[7:6], imm[5:0]}
// where imm is 6'b000000 unless INSTR_LOADER_IMM_EN is defined.
//
// Optional feature macro: INSTR_LOADER_IMM_EN
//   defined   -> adds input in_imm[5:0], packed into word bits [5:0]
//   undefined -> no in_imm port, word bits [5:0] are always zero
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse starting a load session (IDLE/DONE only)
//   in_valid/ready  field bundle handshake
//   in_opcode/rs1/rs2/rd/in_last (and in_imm)  field bundle
//   mem_we/addr/wdata/wready  instruction memory write port
//   busy            session in progress (FILL or FLUSH)
//   done            session finished, held until next start
//   word_count      words written this session, saturates at 2^ADDR_W
//   overflow        sticky: the write address wrapped this session
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic [1:0]        in_rs1,
   input  logic [1:0]        in_rs2,
   input  logic [1:0]        in_rd,
`ifdef INSTR_LOADER_IMM_EN
   input  logic [5:0]        in_imm,
`endif
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_wready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   word_count,
   output logic              overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state_reg, state_next;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [PTR_W:0]    wr_ptr_reg, rd_ptr_reg;
   logic [15:0]       fifo_mem [FIFO_DEPTH];
   logic              fifo_empty, fifo_full;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W:0]   count_reg;
   logic              overflow_reg;
   logic              push, pop, session_clear;
   logic [15:0]       enc_word;

   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                       (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

`ifdef INSTR_LOADER_IMM_EN
   assign enc_word = {in_opcode, in_rs1, in_rs2, in_rd, in_imm};
`else
   assign enc_word = {in_opcode, in_rs1, in_rs2, in_rd, 6'b000000};
`endif

   assign push          = in_valid && in_ready;
   assign pop           = mem_we && mem_wready;
   assign session_clear = start && ((state_reg == IDLE) || (state_reg == DONE));

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = FILL;
         end
         FILL: begin
            busy     = 1'b1;
            // Only fullness gates acceptance; a same-cycle pop does not help.
            in_ready = !fifo_full;
            if (in_valid && !fifo_full && in_last) state_next = FLUSH;
         end
         FLUSH: begin
            busy = 1'b1;
            // Empty FIFO means mem_we is low, so no write is outstanding.
            if (fifo_empty) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_next = FILL;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- write side ----------------
   assign mem_we     = busy && !fifo_empty;
   assign mem_wdata  = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr_reg[PTR_W-1:0]];
   assign mem_addr   = addr_reg;
   assign word_count = count_reg;
   assign overflow   = overflow_reg;

   // Buffer storage: stale entries are harmless because the pointers gate them.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= enc_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || session_clear) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         addr_reg     <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
            // Address wraps naturally; the wrap is remembered in overflow.
            addr_reg   <= addr_reg + ADDR_W'(1);
            if (addr_reg == ADDR_MAX) begin
               overflow_reg <= 1'b1;
            end
            if (count_reg != COUNT_MAX) begin
               count_reg <= count_reg + (ADDR_W+1)'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed testbench for instr_encoder_loader. Two instances share all inputs:
// dut (ADDR_W=8) and dut2 (ADDR_W=2, used for the address wrap case).
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_last, mem_wready;
   logic [3:0]  in_opcode;
   logic [1:0]  in_rs1, in_rs2, in_rd;
`ifdef INSTR_LOADER_IMM_EN
   logic [5:0]  in_imm;
`endif

   logic        in_ready, mem_we, busy, done, overflow;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [8:0]  word_count;

   logic        in_ready2, mem_we2, busy2, done2, overflow2;
   logic [1:0]  mem_addr2;
   logic [15:0] mem_wdata2;
   logic [2:0]  word_count2;

   int checks = 0;
   int errors = 0;

   logic [7:0]  wr_addr_q [$];
   logic [15:0] wr_data_q [$];
   logic [1:0]  wr_addr2_q [$];
   logic        wr_ovf2_q [$];

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
`ifdef INSTR_LOADER_IMM_EN
      .in_imm(in_imm),
`endif
      .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wready(mem_wready), .busy(busy), .done(done), .word_count(word_count),
      .overflow(overflow)
   );

   instr_encoder_loader #(.ADDR_W(2), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
      .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
`ifdef INSTR_LOADER_IMM_EN
      .in_imm(in_imm),
`endif
      .in_last(in_last), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_wready(mem_wready), .busy(busy2), .done(done2), .word_count(word_count2),
      .overflow(overflow2)
   );

   // Inputs change #1 after posedge, so at negedge we see what the next edge commits.
   always @(negedge clk) begin
      if (!rst && mem_we && mem_wready) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
         $display("write dut  addr=%0d data=%04h", mem_addr, mem_wdata);
      end
      if (!rst && mem_we2 && mem_wready) begin
         wr_addr2_q.push_back(mem_addr2);
         wr_ovf2_q.push_back(overflow2);
         $display("write dut2 addr=%0d data=%04h overflow_before=%0b", mem_addr2, mem_wdata2, overflow2);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_addr2_q.delete();
      wr_ovf2_q.delete();
   endtask

   // Offer one bundle until accepted (bounded); returns at posedge+1 after acceptance.
   task automatic send(input logic [3:0] op, input logic [1:0] r1, input logic [1:0] r2,
                       input logic [1:0] rdv, input logic last);
      logic accepted;
      accepted  = 1'b0;
      in_opcode = op; in_rs1 = r1; in_rs2 = r2; in_rd = rdv; in_last = last;
      in_valid  = 1'b1;
      for (int n = 0; n < 100 && !accepted; n++) begin
         @(negedge clk);
         if (in_ready) accepted = 1'b1;
         step();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      $display("send op=%h rs1=%0d rs2=%0d rd=%0d last=%0b accepted=%0b", op, r1, r2, rdv, last, accepted);
      chk("send_accepted", {31'd0, accepted}, 32'd1);
   endtask

   task automatic wait_done(input string tag);
      for (int n = 0; n < 200 && !done; n++) step();
      chk(tag, {31'd0, done}, 32'd1);
   endtask

   logic [3:0]  t2_op  [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hC};
   logic [1:0]  t2_rs1 [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [1:0]  t2_rs2 [5] = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
   logic [1:0]  t2_rd  [5] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
   logic [15:0] t2_exp [5] = '{16'h1180, 16'h24C0, 16'h4A00, 16'h8D40, 16'hC080};
   logic [15:0] t1_exp [3] = '{16'h36C0, 16'hA340, 16'hFFC0};
   logic        t3_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [1:0]  t3_adr [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_wready = 1'b0;
      in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
`ifdef INSTR_LOADER_IMM_EN
      in_imm = '0;
`endif
      step(); step();

      // ---- reset state ----
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_count", word_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst2_outputs", {in_ready2, mem_we2, busy2, done2, overflow2}, 0);
      chk("rst2_wdata", mem_wdata2, 0);
      step();
      rst = 1'b0;

      // ---- basic 3-bundle program ----
      mem_wready = 1'b1;
      pulse_start();
      clear_log();
      send(4'h3, 2'd1, 2'd2, 2'd3, 1'b0);
      send(4'hA, 2'd0, 2'd3, 2'd1, 1'b0);
      send(4'hF, 2'd3, 2'd3, 2'd3, 1'b1);
      wait_done("t1_done");
      @(negedge clk);
      chk("t1_nwrites", wr_addr_q.size(), 3);
      for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
         chk("t1_addr", wr_addr_q[i], i);
         chk("t1_data", wr_data_q[i], t1_exp[i]);
      end
      chk("t1_count", word_count, 3);
      chk("t1_overflow", overflow, 0);
      chk("t1_busy", busy, 0);
      chk("t1_mem_we", mem_we, 0);
      chk("t1_count2", word_count2, 3);
      step();

      // ---- start from DONE, backpressure with full FIFO ----
      mem_wready = 1'b0;
      pulse_start();
      @(negedge clk);
      chk("t2_done_clr", done, 0);
      chk("t2_addr_clr", mem_addr, 0);
      chk("t2_count_clr", word_count, 0);
      chk("t2_we_empty", mem_we, 0);
      step();
      clear_log();
      send(t2_op[0], t2_rs1[0], t2_rs2[0], t2_rd[0], 1'b0);
      @(negedge clk);
      chk("t2_first_we", mem_we, 1);
      chk("t2_first_data", mem_wdata, t2_exp[0]);
      step();
      for (int i = 1; i < 4; i++) send(t2_op[i], t2_rs1[i], t2_rs2[i], t2_rd[i], 1'b0);
      in_opcode = t2_op[4]; in_rs1 = t2_rs1[4]; in_rs2 = t2_rs2[4]; in_rd = t2_rd[4];
      in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_full_ready", in_ready, 0);
         chk("t2_hold_we", mem_we, 1);
         chk("t2_hold_addr", mem_addr, 0);
         chk("t2_hold_data", mem_wdata, t2_exp[0]);
         step();
      end
      mem_wready = 1'b1;
      send(t2_op[4], t2_rs1[4], t2_rs2[4], t2_rd[4], 1'b1);
      wait_done("t2_done");
      @(negedge clk);
      chk("t2_nwrites", wr_addr_q.size(), 5);
      for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
         chk("t2_addr", wr_addr_q[i], i);
         chk("t2_data", wr_data_q[i], t2_exp[i]);
      end
      chk("t2_count", word_count, 5);
      step();

      // ---- address wrap on dut2, start ignored mid-FILL ----
      pulse_start();
      clear_log();
      for (int i = 0; i < 6; i++) begin
         send(4'(i), 2'(i), 2'd0, 2'd0, (i == 5));
         if (i == 1) pulse_start();
      end
      wait_done("t3_done");
      @(negedge clk);
      chk("t3_nwrites2", wr_addr2_q.size(), 6);
      for (int i = 0; i < 6 && i < wr_addr2_q.size(); i++) begin
         chk("t3_addr2", wr_addr2_q[i], t3_adr[i]);
         chk("t3_ovf_before", wr_ovf2_q[i], t3_ovf[i]);
      end
      chk("t3_overflow2", overflow2, 1);
      chk("t3_count2_sat", word_count2, 4);
      chk("t3_count", word_count, 6);
      chk("t3_overflow", overflow, 0);
      step();

      // ---- reset mid-FILL with 2 words buffered ----
      mem_wready = 1'b1;
      pulse_start();
      send(4'h5, 2'd1, 2'd1, 2'd1, 1'b0);
      step(); step();
      mem_wready = 1'b0;
      send(4'h6, 2'd2, 2'd2, 2'd2, 1'b0);
      send(4'h7, 2'd3, 2'd3, 2'd3, 1'b0);
      @(negedge clk);
      chk("t4_pre_count", word_count, 1);
      chk("t4_pre_we", mem_we, 1);
      step();
      clear_log();
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("t4_we", mem_we, 0);
      chk("t4_busy", busy, 0);
      chk("t4_count", word_count, 0);
      chk("t4_in_ready", in_ready, 0);
      rst = 1'b0;
      mem_wready = 1'b1;
      repeat (5) step();
      chk("t4_no_writes", wr_addr_q.size(), 0);
      chk("t4_addr", mem_addr, 0);

`ifdef INSTR_LOADER_IMM_EN
      // ---- immediate field ----
      mem_wready = 1'b0;
      pulse_start();
      in_imm = 6'h2A;
      send(4'h1, 2'd0, 2'd0, 2'd2, 1'b1);
      @(negedge clk);
      chk("imm_wdata", mem_wdata, 16'h10AA);
      step();
      mem_wready = 1'b1;
      wait_done("imm_done");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
